eth_rx_frame_chk: RTL and testbench
===================================

# eth_rx_frame_chk

Ingress frame checker placed directly upstream of the port receive FSM in `eth_sw`. It takes the raw 64-bit word stream from the MAC side and forwards it with a fixed 2-cycle latency. On the way through it enforces framing rules:
- every forwarded frame is bounded by exactly one SOP and one EOP;
- frame length is checked against min/max word counts;
- the `vld` signal must stay asserted for the whole frame.

Malformed frames are closed off with a forced EOP and flagged with `outErr`. The downstream FSM therefore never sees an unterminated frame.

## Interface
Parameters:
- `MIN_WORDS`, default 8. Minimum legal frame length in 64-bit words, counting the SOP and EOP words.
- `MAX_WORDS`, default 190. Maximum legal frame length in words.
- `CNT_W`, default 16. Width of the statistics counters.

Ports (clock and reset first):
- `clk`, input, 1. The single clock; all logic is on the rising edge.
- `resetN`, input, 1. Reset is asynchronous and active-low.
- `inData`, input, 64. Ingress data word.
- `inSop`, input, 1. Start of frame; qualified by `vld`.
- `inEop`, input, 1. End of frame; qualified by `vld`.
- `vld`, input, 1. Ingress word valid.
- `outData`, output, 64. Forwarded data word.
- `outSop`, output, 1. Forwarded start of frame.
- `outEop`, output, 1. Forwarded end of frame, either original or forced.
- `outvld`, output, 1. Forwarded word valid.
- `outErr`, output, 1. Frame error. Meaningful only when `outvld && outEop`.
- `frameOkCnt`, output, `CNT_W`. Number of frames closed without error.
- `frameErrCnt`, output, `CNT_W`. Number of frames closed with `outErr`.
- `dropWordCnt`, output, `CNT_W`. Number of input words discarded.

## Operation
Datapath:
- Stage S1 holds `{err, eop, sop, data, v}`. Stage S2 drives the outputs.
- S1 may be rewritten (forced EOP, set ERR) in the same cycle it moves to S2.
- `wcnt` counts the words of the current frame. Width is `$clog2(MAX_WORDS+1)`.

State machine: IDLE, IN_FRAME, DROP. Transitions are evaluated on each rising edge of `clk`.

IDLE:
- `vld && inSop && !inEop`: load S1, set `wcnt = 1`, go to IN_FRAME.
- `vld && inSop && inEop`: load S1 with ERR set (runt frame); stay in IDLE.
- `vld && !inSop`: the word is a stray. Discard it and increment `dropWordCnt`.

IN_FRAME:
- `vld`, neither SOP nor EOP: load S1 and increment `wcnt`.
  - If the new `wcnt` equals `MAX_WORDS`, force EOP and ERR on this word and go to DROP.
- `vld && inEop && !inSop`: load S1 and increment `wcnt`.
  - Set ERR if the new `wcnt < MIN_WORDS`.
  - Go to IDLE.
- `vld && inSop`: the previous frame was truncated.
  - The word leaving S1 gets EOP and ERR forced.
  - The new word starts a frame exactly as in IDLE, including the runt check when `inEop` is also set.
- `!vld`: the frame has a gap. The word leaving S1 gets EOP and ERR forced; go to IDLE.

DROP:
- Discard every valid word and increment `dropWordCnt` for each.
- `vld && inEop && !inSop`: go to IDLE.
- `vld && inSop`: start a new frame as in IDLE.

Output rules:
- `outErr` is 0 on any word that is not an EOP.
- `outvld` is high only for words that are forwarded.

## Timing
- Latency is exactly 2 cycles: an input word sampled at edge N appears on the outputs after edge N+1.
- Throughput is one word per cycle. There is no backpressure.
- A forced EOP lands on the last word already accepted. No extra word is inserted.
- An EOP with `vld` low in the same cycle is ignored.
- Reset values: all outputs 0, state IDLE, S1 and S2 invalid, all counters 0.
- Reset asserted mid-frame: the frame is lost and no EOP is emitted. Operation resumes in IDLE.
- Counters saturate at all-ones. They increment on the cycle the EOP leaves S2.

## Configuration
- `ETH_RX_STATS_EN` defined: the three saturating counters are implemented.
- `ETH_RX_STATS_EN` undefined: the counter ports remain and are tied to 0. No counter flops are synthesized.

## Structure
Package `eth_pkg` holds:
- the state enum `rx_chk_state_e`;
- the struct `eth_word_s {err, eop, sop, data[63:0]}`;
- the constants `ETH_WORD_W = 64` and `ETH_DEF_MIN_WORDS = 8`.

Sub-module `eth_sat_counter` (parameter `CNT_W`; inputs `inc`, `clk`, `resetN`) is instantiated three times under the macro.

## Test plan
1. Legal 8-word frame (SOP at word 0, EOP at word 7): identical 8 words out, 2 cycles later, `outErr = 0`, `frameOkCnt = 1`.
2. 3-word frame: forwarded intact, EOP word has `outErr = 1`, `frameErrCnt = 1`.
3. SOP at word 5 of an open frame: word 4 is emitted with `outEop = 1, outErr = 1`, and the new frame follows back-to-back.
4. `vld` drops after word 10 of a frame: word 10 is emitted with forced EOP and ERR; state returns to IDLE.
5. 200-word frame with `MAX_WORDS = 190`:
   - word 190 is emitted with EOP and ERR;
   - the remaining 10 words are dropped, so `dropWordCnt = 10`;
   - the next SOP frame passes cleanly.
6. Two stray non-SOP words in IDLE, then `resetN` pulsed mid-frame: nothing is forwarded, and all outputs and counters read 0 after reset.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared state, word and constant definitions for the ingress frame checker.
// No logic of its own; close_err() marks a word as a forced, errored frame end.
package eth_pkg;

  localparam int ETH_WORD_W        = 64;
  localparam int ETH_DEF_MIN_WORDS = 8;

  typedef enum logic [1:0] {
    IDLE,
    IN_FRAME,
    DROP
  } rx_chk_state_e;

  typedef struct packed {
    logic                  err;
    logic                  eop;
    logic                  sop;
    logic [ETH_WORD_W-1:0] data;
  } eth_word_s;

  function automatic eth_word_s close_err(input eth_word_s w);
    eth_word_s r;
    r     = w;
    r.eop = 1'b1;
    r.err = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/eth_sat_counter.sv
// Saturating event counter: increments on the edge after inc is high, holds at all-ones.
// Single-cycle update, no backpressure; async active-low reset clears it.
module eth_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/eth_rx_frame_chk.sv
// Ingress framing checker: fixed 2-cycle pipeline, one word/cycle, no backpressure; bad frames get forced EOP+ERR.
// Statistics counters exist only when ETH_RX_STATS_EN is defined; otherwise the count ports read 0.
module eth_rx_frame_chk
  import eth_pkg::*;
#(
  parameter int MIN_WORDS = ETH_DEF_MIN_WORDS,
  parameter int MAX_WORDS = 190,
  parameter int CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic [ETH_WORD_W-1:0] inData,
  input  logic                  inSop,
  input  logic                  inEop,
  input  logic                  vld,
  output logic [ETH_WORD_W-1:0] outData,
  output logic                  outSop,
  output logic                  outEop,
  output logic                  outvld,
  output logic                  outErr,
  output logic [CNT_W-1:0]      frameOkCnt,
  output logic [CNT_W-1:0]      frameErrCnt,
  output logic [CNT_W-1:0]      dropWordCnt
);

  localparam int                WCNT_W  = $clog2(MAX_WORDS + 1);
  localparam logic [WCNT_W-1:0] MAX_CNT = WCNT_W'(MAX_WORDS);
  localparam logic [WCNT_W-1:0] MIN_CNT = WCNT_W'(MIN_WORDS);

  rx_chk_state_e     state;
  logic [WCNT_W-1:0] wcnt;
  logic [WCNT_W-1:0] wcnt_nxt;
  eth_word_s         s1;
  eth_word_s         s2;
  eth_word_s         s1_exit;
  logic              s1_v;
  logic              s2_v;
  logic              start;
  logic              close_s1;
  logic              hit_max;

  // A new SOP starts a frame from any state; an open frame cut short closes on the word in S1.
  assign start    = vld && inSop;
  assign close_s1 = (state == IN_FRAME) && (!vld || inSop);
  assign wcnt_nxt = wcnt + WCNT_W'(1);
  assign hit_max  = !inEop && (wcnt_nxt == MAX_CNT);
  assign s1_exit  = close_s1 ? close_err(s1) : s1;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
      wcnt  <= '0;
      s1    <= '0;
      s1_v  <= 1'b0;
      s2    <= '0;
      s2_v  <= 1'b0;
    end else begin
      s2   <= s1_exit;
      s2_v <= s1_v;
      if (start) begin
        s1    <= '{err: inEop, eop: inEop, sop: 1'b1, data: inData};
        s1_v  <= 1'b1;
        wcnt  <= WCNT_W'(1);
        state <= inEop ? IDLE : IN_FRAME;
      end else if ((state == IN_FRAME) && vld) begin
        s1   <= '{err:  hit_max || (inEop && (wcnt_nxt < MIN_CNT)),
                  eop:  inEop || hit_max,
                  sop:  1'b0,
                  data: inData};
        s1_v <= 1'b1;
        wcnt <= wcnt_nxt;
        if (hit_max) begin
          state <= DROP;
        end else if (inEop) begin
          state <= IDLE;
        end
      end else begin
        s1   <= '0;
        s1_v <= 1'b0;
        if ((state == IN_FRAME) || (vld && inEop)) begin
          state <= IDLE;
        end
      end
    end
  end

  assign outData = s2.data;
  assign outSop  = s2.sop;
  assign outEop  = s2.eop;
  assign outErr  = s2.err;
  assign outvld  = s2_v;

`ifdef ETH_RX_STATS_EN
  logic ok_inc;
  logic err_inc;
  logic drop_inc;

  assign ok_inc   = s2_v && s2.eop && !s2.err;
  assign err_inc  = s2_v && s2.eop && s2.err;
  assign drop_inc = vld && !inSop && (state != IN_FRAME);

  eth_sat_counter #(.CNT_W(CNT_W)) u_ok_cnt (
    .clk(clk), .resetN(resetN), .inc(ok_inc), .cnt(frameOkCnt)
  );
  eth_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk(clk), .resetN(resetN), .inc(err_inc), .cnt(frameErrCnt)
  );
  eth_sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
    .clk(clk), .resetN(resetN), .inc(drop_inc), .cnt(dropWordCnt)
  );
`else
  assign frameOkCnt  = '0;
  assign frameErrCnt = '0;
  assign dropWordCnt = '0;
`endif

endmodule

// File: tb/tb_eth_rx_frame_chk.sv
// Bench for eth_rx_frame_chk: directed framing cases plus random traffic against an output-log model.
// The model writes the expected word per cycle and edits the logged last word when a frame is cut short.
module tb_eth_rx_frame_chk;

  localparam int MIN_W = 8;
  localparam int MAX_W = 190;
  localparam int CW    = 5;
  localparam int DEPTH = 8192;
  localparam int CMAX  = (1 << CW) - 1;
`ifdef ETH_RX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          resetN;
  logic [63:0]   inData;
  logic          inSop, inEop, vld;
  logic [63:0]   outData;
  logic          outSop, outEop, outvld, outErr;
  logic [CW-1:0] frameOkCnt, frameErrCnt, dropWordCnt;

  eth_rx_frame_chk #(.MIN_WORDS(MIN_W), .MAX_WORDS(MAX_W), .CNT_W(CW)) dut (
    .clk(clk), .resetN(resetN),
    .inData(inData), .inSop(inSop), .inEop(inEop), .vld(vld),
    .outData(outData), .outSop(outSop), .outEop(outEop), .outvld(outvld), .outErr(outErr),
    .frameOkCnt(frameOkCnt), .frameErrCnt(frameErrCnt), .dropWordCnt(dropWordCnt)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic        exp_v   [DEPTH];
  logic        exp_sop [DEPTH];
  logic        exp_eop [DEPTH];
  logic        exp_err [DEPTH];
  logic [63:0] exp_dat [DEPTH];
  bit          open;
  int          flen, last_idx;
  int          ok_acc, err_acc, drop_acc;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at step %0d: got 0x%0h, want 0x%0h", tag, cyc, act, req);
    end
  endtask

  function automatic int sat_inc(input int x);
    return (x < CMAX) ? x + 1 : x;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Input at step c shows up at sample c+1; a cut-short frame retro-marks its last logged word.
  task automatic model(input logic v, input logic s, input logic e, input logic [63:0] d);
    if (cyc + 1 >= DEPTH) begin
      $display("FAIL model_space: step %0d exceeds log depth %0d", cyc, DEPTH);
      $fatal(1, "bench log exhausted");
    end
    exp_v[cyc+1] = 1'b0;
    if (!v) begin
      if (open) begin
        exp_eop[last_idx] = 1'b1;
        exp_err[last_idx] = 1'b1;
      end
      open = 1'b0;
    end else if (s) begin
      if (open) begin
        exp_eop[last_idx] = 1'b1;
        exp_err[last_idx] = 1'b1;
      end
      exp_v[cyc+1]   = 1'b1;
      exp_sop[cyc+1] = 1'b1;
      exp_eop[cyc+1] = e;
      exp_err[cyc+1] = e;
      exp_dat[cyc+1] = d;
      open     = !e;
      flen     = 1;
      last_idx = cyc + 1;
    end else if (open) begin
      flen++;
      exp_v[cyc+1]   = 1'b1;
      exp_sop[cyc+1] = 1'b0;
      exp_eop[cyc+1] = e || (flen == MAX_W);
      exp_err[cyc+1] = (e && flen < MIN_W) || (!e && flen == MAX_W);
      exp_dat[cyc+1] = d;
      if (e || flen == MAX_W) open = 1'b0;
      last_idx = cyc + 1;
    end else begin
      drop_acc = sat_inc(drop_acc);
    end
  endtask

  task automatic step(input logic v, input logic s, input logic e, input logic [63:0] d);
    vld = v; inSop = s; inEop = e; inData = d;
    model(v, s, e, d);
    @(posedge clk);
    @(negedge clk);
    check("outvld", 64'(outvld), 64'(exp_v[cyc]));
    if (exp_v[cyc]) begin
      check("outData", outData, exp_dat[cyc]);
      check("outSop", 64'(outSop), 64'(exp_sop[cyc]));
      check("outEop", 64'(outEop), 64'(exp_eop[cyc]));
      check("outErr", 64'(outErr), 64'(exp_err[cyc]));
    end
    check("frameOkCnt", 64'(frameOkCnt), 64'(STATS ? ok_acc : 0));
    check("frameErrCnt", 64'(frameErrCnt), 64'(STATS ? err_acc : 0));
    check("dropWordCnt", 64'(dropWordCnt), 64'(STATS ? drop_acc : 0));
    if (exp_v[cyc] && exp_eop[cyc]) begin
      if (exp_err[cyc]) err_acc = sat_inc(err_acc);
      else              ok_acc  = sat_inc(ok_acc);
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'($urandom), 1'($urandom), rnd64());
  endtask

  task automatic frame(input int n, input bit close, input int gap_pct);
    for (int i = 0; i < n; i++) begin
      if (i > 0 && gap_pct > 0 && $urandom_range(99) < gap_pct)
        step(1'b0, 1'($urandom), 1'($urandom), rnd64());
      step(1'b1, i == 0, close && (i == n - 1), rnd64());
    end
  endtask

  task automatic do_reset();
    resetN = 1'b0; vld = 1'b0; inSop = 1'b0; inEop = 1'b0; inData = '0;
    #1;
    check("rst_outvld", 64'(outvld), 64'(0));
    check("rst_outData", outData, 64'(0));
    check("rst_outSop", 64'(outSop), 64'(0));
    check("rst_outEop", 64'(outEop), 64'(0));
    check("rst_outErr", 64'(outErr), 64'(0));
    check("rst_frameOkCnt", 64'(frameOkCnt), 64'(0));
    check("rst_frameErrCnt", 64'(frameErrCnt), 64'(0));
    check("rst_dropWordCnt", 64'(dropWordCnt), 64'(0));
    @(posedge clk);
    @(negedge clk);
    resetN = 1'b1;
    open = 1'b0; flen = 0; last_idx = 0;
    ok_acc = 0; err_acc = 0; drop_acc = 0;
    for (int i = cyc; i < DEPTH; i++) begin
      exp_v[i] = 1'b0; exp_sop[i] = 1'b0; exp_eop[i] = 1'b0; exp_err[i] = 1'b0; exp_dat[i] = '0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached at step %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetN = 1'b1; vld = 1'b0; inSop = 1'b0; inEop = 1'b0; inData = '0;
    #2 do_reset();

    frame(8, 1'b1, 0);   idle(3);
    frame(3, 1'b1, 0);   idle(3);
    frame(5, 1'b0, 0);   frame(8, 1'b1, 0);   idle(3);
    frame(11, 1'b0, 0);  idle(3);
    frame(200, 1'b1, 0); frame(8, 1'b1, 0);   idle(3);
    frame(190, 1'b1, 0); frame(7, 1'b1, 0);   frame(1, 1'b1, 0); frame(1, 1'b1, 0); idle(2);
    frame(195, 1'b0, 0); frame(9, 1'b1, 0);   idle(2);

    step(1'b1, 1'b0, 1'b0, rnd64());
    step(1'b1, 1'b0, 1'b1, rnd64());
    frame(4, 1'b0, 0);
    do_reset();
    idle(3);

    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(9) == 0) step(1'b1, 1'b0, 1'($urandom), rnd64());
      frame(int'($urandom_range(24, 1)), $urandom_range(4) != 0, 5);
      idle(int'($urandom_range(2)));
    end
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
